noc_pe_iface: RTL and testbench
===============================

# noc_pe_iface

Processing-element network interface for the 4-node NoC ring router. It sits directly upstream and downstream of one router node. On transmit, it turns core requests (destination, tag, payload) into 64-bit ring packets with shortest-path direction and hop encoding, then injects them on the node's pesi/pedi port under polarity and peri flow control. On receive, it buffers packets delivered on peso/pedo in a small FIFO, applies pero back-pressure, and hands them to the core through a valid/ready port.

## Interface
- PAC_SIZE, 64, packet width; fields fixed as {vc[63], dir[62], res[61:56], hop[55:48], src[47:32], payload[31:0]}
- NODE_ID, 0, this node's ring position, 0..3
- INJ_POL, 0, polarity value during which this node may inject; the vc field is set to INJ_POL
- RX_DEPTH, 4, receive FIFO entries, power of two, ≥2

- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- polarity  in  1  router node polarity
- peri  in  1  router ready to accept an injected packet
- pesi  out  1  inject strobe, one cycle per packet
- pedi  out  PAC_SIZE  injected packet
- peso  in  1  router delivering a packet
- pedo  in  PAC_SIZE  delivered packet
- pero  out  1  interface ready to accept a delivered packet
- tx_valid / tx_ready  in / out  1  core transmit handshake
- tx_dst  in  2  destination node
- tx_tag  in  6  copied into the res field
- tx_payload  in  32  payload
- tx_self_err  out  1  one-cycle pulse when a request with tx_dst == NODE_ID is dropped
- rx_valid / rx_ready  out / in  1  core receive handshake
- rx_pkt  out  PAC_SIZE  head-of-FIFO packet
- rx_ovf  out  1  sticky; set when a packet arrives while the FIFO is full
- tx_cnt, rx_cnt  out  16  packets injected / packets accepted; wrap at 2^16

## Operation
- Distance d = (tx_dst − NODE_ID) mod 4; the subtraction is 2-bit and wraps.
  - d=1: dir=0, hop=8'b0000_0001
  - d=2: dir=0, hop=8'b0000_0011
  - d=3: dir=1, hop=8'b0000_0001
  - d=0: request accepted, not injected; tx_self_err pulses.
- Packet fields: src = {14'b0, NODE_ID}, vc = INJ_POL, res = tx_tag, payload = tx_payload.
- TX FSM has three states: IDLE, WAIT, SEND.
  - IDLE: tx_ready=1. On tx_valid, latch the packet. Go to WAIT, or stay in IDLE and pulse tx_self_err if d=0.
  - WAIT: tx_ready=0. When polarity==INJ_POL && peri at a rising edge, go to SEND.
  - SEND: pesi=1 for exactly one cycle, then go to IDLE and increment tx_cnt.
- pedi is registered and holds the last built packet outside SEND.
- RX FIFO: write when peso && pero; pero = (count < RX_DEPTH); pop when rx_valid && rx_ready.
- If peso arrives with pero=0, the packet is discarded and rx_ovf is set; only reset clears rx_ovf.
- rx_cnt increments on each FIFO write.

## Timing
- Reset values (asynchronous, immediate):
  - pesi=0, pedi=0, tx_ready=1, tx_self_err=0
  - rx_valid=0, rx_pkt=0, pero=1, rx_ovf=0
  - counters 0, FSM in IDLE, FIFO empty
- Accept at edge k: pesi high in cycle k+2 at the earliest (WAIT is entered at k+1 and the condition is checked at edge k+1). tx_ready returns high the cycle after SEND.
- WAIT has no timeout: polarity or peri may stay unfavourable indefinitely, and the packet is held unchanged.
- RX latency: a packet written at edge k appears as rx_valid in cycle k+1. There is no bypass when the FIFO is empty.
- Simultaneous push and pop: count is unchanged. When full, pero is already 0, so no push can occur. A pop at a full FIFO raises pero the next cycle.
- Pointers are log2(RX_DEPTH) bits and wrap naturally; count is log2(RX_DEPTH)+1 bits.
- Reset asserted mid-operation discards any held TX packet and all FIFO contents.

## Structure
- Package noc_pkg holds:
  - field offsets/widths (VC_BIT, DIR_BIT, RES_LSB, HOP_LSB, SRC_LSB)
  - HOP_1 = 8'h01 and HOP_2 = 8'h03
  - DIR_CW = 0 and DIR_CCW = 1
  - the TX state encoding (IDLE, WAIT, SEND)
- Sub-module noc_rx_fifo: parameterised synchronous FIFO (push, pop, full, empty, count) with asynchronous active-low reset.
- Top level holds the TX FSM, route/encode logic, counters and rx_ovf.

## Test plan
- NODE_ID=0, INJ_POL=0: tx_dst=2, tag=5, payload=2, with polarity=0 and peri=1 -> pesi for one cycle at accept+2, pedi=64'h0503_0000_0000_0002, tx_cnt=1.
- NODE_ID=2, INJ_POL=1: tx_dst=1 with polarity=0 for 6 cycles, then 1 -> no pesi while polarity=0, then pedi with vc=1, dir=1, hop=01, src=2, and tx_ready=0 throughout the wait.
- tx_dst=NODE_ID -> tx_self_err pulses for one cycle, pesi stays 0, tx_ready stays 1.
- RX_DEPTH=4, rx_ready=0, five peso strobes that ignore pero -> four packets stored, pero=0 after the fourth, rx_ovf=1, rx_cnt=4. Then drain with rx_ready=1 -> packets out in order, one per cycle.
- Concurrent push and pop at count=2 for 10 cycles -> count stays at 2, data is in order, and pero stays 1.
- reset_n low while in WAIT and with the FIFO holding 3 packets -> pesi=0, rx_valid=0, pero=1, counters 0 immediately; the next request behaves as fresh.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared packet layout, route encodings and TX state encoding for the PE ring interface.
// Route helper is pure combinational; no storage lives here.
package noc_pkg;

  localparam int PAC_W   = 64;
  localparam int VC_BIT  = 63;
  localparam int DIR_BIT = 62;
  localparam int RES_LSB = 56;
  localparam int RES_W   = 6;
  localparam int HOP_LSB = 48;
  localparam int HOP_W   = 8;
  localparam int SRC_LSB = 32;
  localparam int SRC_W   = 16;
  localparam int PAY_W   = 32;

  localparam logic [HOP_W-1:0] HOP_1 = 8'h01;
  localparam logic [HOP_W-1:0] HOP_2 = 8'h03;

  localparam logic DIR_CW  = 1'b0;
  localparam logic DIR_CCW = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SEND = 2'd2
  } tx_state_t;

  // Field order mirrors VC_BIT..payload so the struct packs straight onto the ring bus.
  typedef struct packed {
    logic             vc;
    logic             dir;
    logic [RES_W-1:0] res;
    logic [HOP_W-1:0] hop;
    logic [SRC_W-1:0] src;
    logic [PAY_W-1:0] payload;
  } pkt_t;

  typedef struct packed {
    logic             is_self;
    logic             dir;
    logic [HOP_W-1:0] hop;
  } route_t;

  // Shortest path on a 4-node ring: the 2-bit difference wraps, so d=3 is one hop counter-clockwise.
  function automatic route_t route_calc(input logic [1:0] dst, input logic [1:0] node);
    logic [1:0] d;
    route_t     r;
    d = dst - node;
    r = '{is_self: 1'b0, dir: DIR_CW, hop: HOP_1};
    case (d)
      2'd0: r.is_self = 1'b1;
      2'd1: r.hop = HOP_1;
      2'd2: r.hop = HOP_2;
      default: begin
        r.dir = DIR_CCW;
        r.hop = HOP_1;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/noc_rx_fifo.sv
// Synchronous FIFO: push visible at head one cycle later, no bypass; push ignored when full,
// pop ignored when empty. Contents are discarded on reset via the pointers and count.
module noc_rx_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/noc_pe_iface.sv
// PE network interface: builds ring packets from core requests (inject 2+ cycles after accept,
// held in WAIT until polarity/peri allow) and buffers delivered packets (pero drops when FIFO full).
module noc_pe_iface
  import noc_pkg::*;
#(
  parameter int   PAC_SIZE = 64,
  parameter int   NODE_ID  = 0,
  parameter logic INJ_POL  = 1'b0,
  parameter int   RX_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                polarity,
  input  logic                peri,
  output logic                pesi,
  output logic [PAC_SIZE-1:0] pedi,
  input  logic                peso,
  input  logic [PAC_SIZE-1:0] pedo,
  output logic                pero,
  input  logic                tx_valid,
  output logic                tx_ready,
  input  logic [1:0]          tx_dst,
  input  logic [5:0]          tx_tag,
  input  logic [31:0]         tx_payload,
  output logic                tx_self_err,
  output logic                rx_valid,
  input  logic                rx_ready,
  output logic [PAC_SIZE-1:0] rx_pkt,
  output logic                rx_ovf,
  output logic [15:0]         tx_cnt,
  output logic [15:0]         rx_cnt
);

  localparam logic [1:0] NODE = 2'(NODE_ID);
  localparam int         CW   = $clog2(RX_DEPTH) + 1;

  tx_state_t state;
  route_t    rt;
  pkt_t      pkt_nxt;
  pkt_t      pedi_q;
  logic      inj_ok;

  always_comb begin
    rt      = route_calc(tx_dst, NODE);
    pkt_nxt = '{vc: INJ_POL, dir: rt.dir, res: tx_tag, hop: rt.hop,
                src: {14'b0, NODE}, payload: tx_payload};
  end

  assign inj_ok = (polarity == INJ_POL) && peri;
  assign pedi   = pedi_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pedi_q      <= '0;
      pesi        <= 1'b0;
      tx_ready    <= 1'b1;
      tx_self_err <= 1'b0;
      tx_cnt      <= '0;
    end else begin
      tx_self_err <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid) begin
            // Self-addressed requests are consumed so the core never stalls on them.
            if (rt.is_self) begin
              tx_self_err <= 1'b1;
            end else begin
              pedi_q   <= pkt_nxt;
              tx_ready <= 1'b0;
              state    <= WAIT;
            end
          end
        end
        WAIT: begin
          if (inj_ok) begin
            pesi  <= 1'b1;
            state <= SEND;
          end
        end
        SEND: begin
          pesi     <= 1'b0;
          tx_ready <= 1'b1;
          tx_cnt   <= tx_cnt + 16'd1;
          state    <= IDLE;
        end
        default: begin
          pesi     <= 1'b0;
          tx_ready <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

  logic                push;
  logic                pop;
  logic                full;
  logic                empty;
  logic [CW-1:0]       count;
  logic [PAC_SIZE-1:0] head;

  assign pero     = (count < CW'(RX_DEPTH));
  assign push     = peso && pero;
  assign rx_valid = !empty;
  assign pop      = rx_valid && rx_ready;
  // Storage is not reset, so the head is masked until something has been written.
  assign rx_pkt   = empty ? '0 : head;

  noc_rx_fifo #(
    .WIDTH(PAC_SIZE),
    .DEPTH(RX_DEPTH)
  ) u_rx_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .push_dat (pedo),
    .pop      (pop),
    .pop_dat  (head),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_ovf <= 1'b0;
      rx_cnt <= '0;
    end else begin
      if (peso && full) rx_ovf <= 1'b1;
      if (push)         rx_cnt <= rx_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_noc_pe_iface.sv
// Bench for noc_pe_iface: node 0 / polarity 0 and node 2 / polarity 1 instances share clock and reset;
// expected packets are queued at stimulus time and popped by monitors on pesi and rx handshakes.
module tb_noc_pe_iface;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic        polarity0, peri0, pesi0, peso0, pero0, tx_valid0, tx_ready0, tx_self_err0;
  logic        rx_valid0, rx_ready0, rx_ovf0;
  logic [63:0] pedi0, pedo0, rx_pkt0;
  logic [1:0]  tx_dst0;
  logic [5:0]  tx_tag0;
  logic [31:0] tx_payload0;
  logic [15:0] tx_cnt0, rx_cnt0;

  logic        polarity2, peri2, pesi2, peso2, pero2, tx_valid2, tx_ready2, tx_self_err2;
  logic        rx_valid2, rx_ready2, rx_ovf2;
  logic [63:0] pedi2, pedo2, rx_pkt2;
  logic [1:0]  tx_dst2;
  logic [5:0]  tx_tag2;
  logic [31:0] tx_payload2;
  logic [15:0] tx_cnt2, rx_cnt2;

  logic [63:0] txq0[$];
  logic [63:0] txq2[$];
  logic [63:0] rxq0[$];

  noc_pe_iface #(.PAC_SIZE(64), .NODE_ID(0), .INJ_POL(1'b0), .RX_DEPTH(4)) u0 (
    .clk(clk), .reset_n(reset_n), .polarity(polarity0), .peri(peri0), .pesi(pesi0), .pedi(pedi0),
    .peso(peso0), .pedo(pedo0), .pero(pero0), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
    .tx_dst(tx_dst0), .tx_tag(tx_tag0), .tx_payload(tx_payload0), .tx_self_err(tx_self_err0),
    .rx_valid(rx_valid0), .rx_ready(rx_ready0), .rx_pkt(rx_pkt0), .rx_ovf(rx_ovf0),
    .tx_cnt(tx_cnt0), .rx_cnt(rx_cnt0)
  );

  noc_pe_iface #(.PAC_SIZE(64), .NODE_ID(2), .INJ_POL(1'b1), .RX_DEPTH(4)) u2 (
    .clk(clk), .reset_n(reset_n), .polarity(polarity2), .peri(peri2), .pesi(pesi2), .pedi(pedi2),
    .peso(peso2), .pedo(pedo2), .pero(pero2), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
    .tx_dst(tx_dst2), .tx_tag(tx_tag2), .tx_payload(tx_payload2), .tx_self_err(tx_self_err2),
    .rx_valid(rx_valid2), .rx_ready(rx_ready2), .rx_pkt(rx_pkt2), .rx_ovf(rx_ovf2),
    .tx_cnt(tx_cnt2), .rx_cnt(rx_cnt2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset_n && pesi0) begin
      if (txq0.size() == 0) check("pesi0_unexpected", 64'(pesi0), 64'd0);
      else check("pedi0", pedi0, txq0.pop_front());
    end
    if (reset_n && pesi2) begin
      if (txq2.size() == 0) check("pesi2_unexpected", 64'(pesi2), 64'd0);
      else check("pedi2", pedi2, txq2.pop_front());
    end
    if (reset_n && rx_valid0 && rx_ready0) begin
      if (rxq0.size() == 0) check("rx0_unexpected", 64'(rx_valid0), 64'd0);
      else check("rx_pkt0", rx_pkt0, rxq0.pop_front());
    end
  end

  initial begin
    repeat (5000) @(posedge clk);
    $display("FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1);
  end

  // Node 0 request; peri held low for 'hold' cycles after acceptance, then pesi expected next cycle.
  task automatic tx0(input logic [1:0] dst, input logic [5:0] tag, input logic [31:0] pay,
                     input logic [63:0] exp, input int hold);
    polarity0 = 1'b0;
    peri0 = (hold == 0);
    tx_valid0 = 1'b1; tx_dst0 = dst; tx_tag0 = tag; tx_payload0 = pay;
    txq0.push_back(exp);
    tick();
    tx_valid0 = 1'b0;
    check("tx0_ready_low_after_accept", 64'(tx_ready0), 64'd0);
    for (int i = 0; i < hold; i++) begin
      check("tx0_no_pesi_peri_low", 64'(pesi0), 64'd0);
      tick();
    end
    peri0 = 1'b1;
    tick();
    check("tx0_pesi_high", 64'(pesi0), 64'd1);
    tick();
    check("tx0_pesi_one_cycle", 64'(pesi0), 64'd0);
    check("tx0_ready_back", 64'(tx_ready0), 64'd1);
  endtask

  initial begin
    polarity0 = 0; peri0 = 0; peso0 = 0; pedo0 = '0; tx_valid0 = 0; rx_ready0 = 0;
    tx_dst0 = '0; tx_tag0 = '0; tx_payload0 = '0;
    polarity2 = 0; peri2 = 0; peso2 = 0; pedo2 = '0; tx_valid2 = 0; rx_ready2 = 0;
    tx_dst2 = '0; tx_tag2 = '0; tx_payload2 = '0;
    #12;
    check("rst_pesi", 64'(pesi0), 64'd0);
    check("rst_pedi", pedi0, 64'd0);
    check("rst_tx_ready", 64'(tx_ready0), 64'd1);
    check("rst_self_err", 64'(tx_self_err0), 64'd0);
    check("rst_rx_valid", 64'(rx_valid0), 64'd0);
    check("rst_rx_pkt", rx_pkt0, 64'd0);
    check("rst_pero", 64'(pero0), 64'd1);
    check("rst_rx_ovf", 64'(rx_ovf0), 64'd0);
    check("rst_tx_cnt", 64'(tx_cnt0), 64'd0);
    check("rst_rx_cnt", 64'(rx_cnt0), 64'd0);
    check("rst2_pesi", 64'(pesi2), 64'd0);
    check("rst2_self_err", 64'(tx_self_err2), 64'd0);
    check("rst2_rx", {rx_pkt2[61:0], rx_valid2, rx_ovf2}, 64'd0);
    check("rst2_pero", 64'(pero2), 64'd1);
    check("rst2_cnts", {32'd0, tx_cnt2, rx_cnt2}, 64'd0);
    check("rst2_pedi", pedi2, 64'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // Routing vectors on node 0: d=2, d=1 with peri stall, d=3.
    tx0(2'd2, 6'd5,     32'd2,          64'h0503_0000_0000_0002, 0);
    tx0(2'd1, 6'd3,     32'h1234_5678,  64'h0301_0000_1234_5678, 3);
    tx0(2'd3, 6'h3F,    32'hA5A5_A5A5,  64'h7F01_0000_A5A5_A5A5, 0);
    check("tx0_cnt_3", 64'(tx_cnt0), 64'd3);

    // Self-addressed request.
    tx_valid0 = 1'b1; tx_dst0 = 2'd0; tx_tag0 = 6'd9; tx_payload0 = 32'h1;
    tick();
    tx_valid0 = 1'b0;
    check("self_err_pulse", 64'(tx_self_err0), 64'd1);
    check("self_tx_ready", 64'(tx_ready0), 64'd1);
    check("self_no_pesi", 64'(pesi0), 64'd0);
    tick();
    check("self_err_drop", 64'(tx_self_err0), 64'd0);
    check("self_no_pesi2", 64'(pesi0), 64'd0);
    check("self_tx_cnt", 64'(tx_cnt0), 64'd3);

    // Node 2, INJ_POL=1: held off by polarity for 6 cycles.
    polarity2 = 1'b0; peri2 = 1'b1;
    tx_valid2 = 1'b1; tx_dst2 = 2'd1; tx_tag2 = 6'h2A; tx_payload2 = 32'hDEAD_BEEF;
    txq2.push_back(64'hEA01_0002_DEAD_BEEF);
    tick();
    tx_valid2 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("n2_wait_no_pesi", 64'(pesi2), 64'd0);
      check("n2_wait_tx_ready", 64'(tx_ready2), 64'd0);
      tick();
    end
    polarity2 = 1'b1;
    tick();
    check("n2_pesi", 64'(pesi2), 64'd1);
    tick();
    check("n2_pesi_low", 64'(pesi2), 64'd0);
    check("n2_tx_ready", 64'(tx_ready2), 64'd1);
    check("n2_tx_cnt", 64'(tx_cnt2), 64'd1);

    // Overflow: five strobes into a 4-entry FIFO with the core stalled.
    rx_ready0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      peso0 = 1'b1;
      pedo0 = 64'h1000 + 64'(i);
      if (i < 4) rxq0.push_back(64'h1000 + 64'(i));
      tick();
      if (i == 2) check("ovf_pero_before_full", 64'(pero0), 64'd1);
      if (i == 3) begin
        check("ovf_pero_full", 64'(pero0), 64'd0);
        check("ovf_not_yet", 64'(rx_ovf0), 64'd0);
      end
    end
    peso0 = 1'b0;
    check("ovf_sticky", 64'(rx_ovf0), 64'd1);
    check("ovf_rx_cnt", 64'(rx_cnt0), 64'd4);
    check("ovf_head", rx_pkt0, 64'h1000);
    rx_ready0 = 1'b1;
    tick();
    check("drain_pero_up", 64'(pero0), 64'd1);
    repeat (3) tick();
    check("drain_empty", 64'(rx_valid0), 64'd0);
    check("drain_queue", 64'(rxq0.size()), 64'd0);
    rx_ready0 = 1'b0;

    // Concurrent push/pop at count=2.
    for (int i = 0; i < 2; i++) begin
      peso0 = 1'b1; pedo0 = 64'h2000 + 64'(i);
      rxq0.push_back(64'h2000 + 64'(i));
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      peso0 = 1'b1; pedo0 = 64'h3000 + 64'(i); rx_ready0 = 1'b1;
      rxq0.push_back(64'h3000 + 64'(i));
      tick();
      check("conc_pero", 64'(pero0), 64'd1);
      check("conc_rx_valid", 64'(rx_valid0), 64'd1);
    end
    peso0 = 1'b0;
    tick();
    check("conc_one_left", 64'(rx_valid0), 64'd1);
    tick();
    check("conc_empty", 64'(rx_valid0), 64'd0);
    rx_ready0 = 1'b0;
    check("conc_rx_cnt", 64'(rx_cnt0), 64'd16);

    // Reset while WAITing with three packets buffered.
    polarity0 = 1'b1; peri0 = 1'b1;
    tx_valid0 = 1'b1; tx_dst0 = 2'd1; tx_tag0 = 6'd1; tx_payload0 = 32'h55;
    peso0 = 1'b1; pedo0 = 64'h4000;
    tick();
    tx_valid0 = 1'b0;
    pedo0 = 64'h4001;
    tick();
    pedo0 = 64'h4002;
    tick();
    peso0 = 1'b0;
    check("pre_rst_wait", 64'(tx_ready0), 64'd0);
    check("pre_rst_rx_valid", 64'(rx_valid0), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_pesi", 64'(pesi0), 64'd0);
    check("mid_rst_rx_valid", 64'(rx_valid0), 64'd0);
    check("mid_rst_pero", 64'(pero0), 64'd1);
    check("mid_rst_cnts", {32'd0, tx_cnt0, rx_cnt0}, 64'd0);
    check("mid_rst_ovf", 64'(rx_ovf0), 64'd0);
    check("mid_rst_tx_ready", 64'(tx_ready0), 64'd1);
    tick();
    reset_n = 1'b1;
    tick();
    tx0(2'd2, 6'd0, 32'h0000_CAFE, 64'h0003_0000_0000_CAFE, 0);
    check("post_rst_tx_cnt", 64'(tx_cnt0), 64'd1);
    check("post_rst_rx_cnt", 64'(rx_cnt0), 64'd0);

    check("end_txq0", 64'(txq0.size()), 64'd0);
    check("end_txq2", 64'(txq2.size()), 64'd0);
    check("end_rxq0", 64'(rxq0.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
